memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/memory_stage_if.sv | 28 ++
 rtl/memory_stage_dmem.sv | 45 ++++
 rtl/memory_stage.sv | 152 +++++++++++++++
 tb/tb_memory_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 memory stage:
//   - instruction codes that touch data memory
//   - data-memory geometry (word count, byte size, index field position)
//   - memory-stage FSM state type
//   - small decode helpers used by the stage and its testbench-facing logic
// -----------------------------------------------------------------------------
package y86_pkg;

  // Instruction codes that access data memory
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Data memory geometry: 256 words of 64 bits = 2048 bytes
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned MEM_WORDS  = 256;
  localparam int unsigned MEM_BYTES  = MEM_WORDS * WORD_BYTES;
  localparam int unsigned IDX_W      = 8;   // word index width
  localparam int unsigned IDX_LSB    = 3;   // word index = addr[10:3]

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACCESS,
    ST_RESP
  } mem_state_e;

  function automatic logic is_write_op(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

  function automatic logic is_read_op(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] ic);
    return is_write_op(ic) || is_read_op(ic);
  endfunction

  // ret/popq address memory through the stack pointer carried in valA
  function automatic logic addr_from_vala(input logic [3:0] ic);
    return (ic == IRET) || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Execute-to-memory request/response bundle.
//   master (execute side): drives start, icode, valE, valA, valP;
//                          observes valM, done, busy, dmem_error
//   slave  (memory stage): the reverse
// -----------------------------------------------------------------------------
interface memory_stage_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        done;
  logic        busy;
  logic        dmem_error;

  modport master (
    output start, icode, valE, valA, valP,
    input  valM, done, busy, dmem_error
  );

  modport slave (
    input  start, icode, valE, valA, valP,
    output valM, done, busy, dmem_error
  );
endinterface

// File: rtl/memory_stage_dmem.sv
// -----------------------------------------------------------------------------
// dmem_array
// 256 x 64-bit data memory with synchronous write and registered read.
// Contents are not affected by reset; only the read register is cleared.
// Ports:
//   clk       clock
//   rst_n     async active-low reset (read register only)
//   we_i      write enable, commits wdata_i at the rising edge
//   re_i      read enable, captures the addressed word at the rising edge
//   idx_i     word index
//   wdata_i   write data
//   rdata_o   registered read data
// -----------------------------------------------------------------------------
module dmem_array
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [MEM_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Y86-64 memory stage: accepts one request from execute, performs at most one
// data-memory word access, and reports completion with a single-cycle done.
//   IDLE   -> accept start, latch operands
//   ADDR   -> select address, compute fault
//   ACCESS -> write commits / read is registered on the edge leaving ACCESS
//   RESP   -> done=1, valM/dmem_error presented and then held
// No-access instruction codes skip straight from IDLE to RESP.
// Ports:
//   clk    clock
//   rst_n  async active-low reset (memory contents are preserved)
//   bus    memory_stage_if.slave: start/icode/valE/valA/valP in,
//          valM/done/busy/dmem_error out
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, a non-zero addr[2:0] also faults
// -----------------------------------------------------------------------------
module memory_stage
  import y86_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  memory_stage_if.slave  bus
);

  mem_state_e        state_q, state_d;
  logic [3:0]        icode_q, icode_d;
  logic [WORD_W-1:0] valE_q,  valE_d;
  logic [WORD_W-1:0] valA_q,  valA_d;
  logic [WORD_W-1:0] valP_q,  valP_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              fault_q, fault_d;
  logic [WORD_W-1:0] valm_q,  valm_d;
  logic              err_q,   err_d;

  logic [WORD_W-1:0] addr_sel;
  logic              addr_fault;
  logic [WORD_W-1:0] wdata;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] resp_valm;

  // Address source and fault check, evaluated from the latched operands
  always_comb begin
    addr_sel   = addr_from_vala(icode_q) ? valA_q : valE_q;
    addr_fault = (addr_sel >= WORD_W'(MEM_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
    if (addr_sel[IDX_LSB-1:0] != '0) begin
      addr_fault = 1'b1;
    end
`endif
  end

  assign wdata  = (icode_q == ICALL) ? valP_q : valA_q;
  assign mem_we = (state_q == ST_ACCESS) && is_write_op(icode_q) && !fault_q;
  assign mem_re = (state_q == ST_ACCESS) && is_read_op(icode_q);

  dmem_array u_dmem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (idx_q),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // Value presented during RESP: zero on fault, fresh data on a read,
  // otherwise the previously returned value carries over.
  always_comb begin
    if (fault_q) begin
      resp_valm = '0;
    end else if (is_read_op(icode_q)) begin
      resp_valm = rdata;
    end else begin
      resp_valm = valm_q;
    end
  end

  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    valP_d  = valP_q;
    idx_d   = idx_q;
    fault_d = fault_q;
    valm_d  = valm_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          icode_d = bus.icode;
          valE_d  = bus.valE;
          valA_d  = bus.valA;
          valP_d  = bus.valP;
          fault_d = 1'b0;
          state_d = is_mem_op(bus.icode) ? ST_ADDR : ST_RESP;
        end
      end
      ST_ADDR: begin
        idx_d   = addr_sel[IDX_LSB +: IDX_W];
        fault_d = addr_fault;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        valm_d  = resp_valm;
        err_d   = fault_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      icode_q <= '0;
      valE_q  <= '0;
      valA_q  <= '0;
      valP_q  <= '0;
      idx_q   <= '0;
      fault_q <= 1'b0;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      valP_q  <= valP_d;
      idx_q   <= idx_d;
      fault_q <= fault_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  // During RESP the new result is shown directly so it coincides with done;
  // the held copy is updated on the edge leaving RESP.
  assign bus.done       = (state_q == ST_RESP);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.valM       = bus.done ? resp_valm : valm_q;
  assign bus.dmem_error = bus.done ? fault_q   : err_q;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Scoreboard bench for memory_stage. The driver computes each request's
// expected response from a word-array reference model and queues it; a
// monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_stage_if bus ();

  memory_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_x;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  bit          chk_after = 1'b0;
  logic [63:0] last_valm = '0;

  // Reference model: 256 words, plus the value valM currently holds
  logic [63:0] ref_mem [256];
  logic [63:0] ref_valm = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_op(input logic [3:0] ic, input logic [63:0] e, a, p,
                                 output logic [63:0] vm, output logic er, output bit mem);
    bit          rd, wr, fault;
    logic [63:0] addr;
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    mem  = rd || wr;
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    if (!mem) begin
      vm = ref_valm;
      er = 1'b0;
      return;
    end
    fault = (addr >= 64'd2048);
`ifdef MEM_ALIGN_CHECK_EN
    if ((addr % 8) != 0) fault = 1'b1;
`endif
    if (fault)   vm = '0;
    else if (rd) vm = ref_mem[int'(addr / 8)];
    else         vm = ref_valm;
    if (!fault && wr) ref_mem[int'(addr / 8)] = (ic == 4'h8) ? p : a;
    er       = fault;
    ref_valm = vm;
  endfunction

  task automatic wait_idle();
    int unsigned n = 0;
    while (bus.busy || bus.done) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL idle_wait: busy still %b after %0d cycles, required 0", bus.busy, n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
        $fatal(1, "stage never returned to idle");
      end
    end
  endtask

  // Issue one request; optionally hold start for a second cycle with junk
  // operands, which the stage must ignore.
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, a, p, input bit second);
    exp_t x;
    bit   mem;
    wait_idle();
    ref_op(ic, e, a, p, x.valm, x.err, mem);
    // done lands in the 3rd (memory) or 1st (no-access) cycle after acceptance
    x.due     = cyc + 1 + (mem ? 2 : 0);
    bus.start = 1'b1;
    bus.icode = ic;
    bus.valE  = e;
    bus.valA  = a;
    bus.valP  = p;
    exp_q.push_back(x);
    @(negedge clk);
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    if (second) begin
      bus.icode = 4'($urandom);
      bus.valE  = {$urandom, $urandom};
      bus.valA  = {$urandom, $urandom};
      bus.valP  = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_after = 1'b0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 with no request outstanding, required 0 (cycle %0d)", cyc);
      end else begin
        mon_x = exp_q.pop_front();
        check("valM", bus.valM, mon_x.valm);
        check("dmem_error", {63'd0, bus.dmem_error}, {63'd0, mon_x.err});
        check("done_latency", 64'(cyc), 64'(mon_x.due));
        check("busy_at_done", {63'd0, bus.busy}, 64'd1);
        last_valm = mon_x.valm;
        chk_after = 1'b1;
      end
    end else if (chk_after) begin
      check("busy_after_done", {63'd0, bus.busy}, 64'd0);
      check("valM_hold", bus.valM, last_valm);
      chk_after = 1'b0;
    end
  end

  logic [3:0] mem_codes [6];

  initial begin
    int unsigned n;
    logic [3:0]  ic;
    logic [63:0] addr;
    int unsigned k;

    mem_codes = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    foreach (ref_mem[i]) ref_mem[i] = '0;
    bus.start = 1'b0;
    bus.icode = '0;
    bus.valE  = '0;
    bus.valA  = '0;
    bus.valP  = '0;
    rst_n     = 1'b0;
    #1;
    check("reset_valM", bus.valM, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_err", {63'd0, bus.dmem_error}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero every word the random phase can touch
    for (int unsigned w = 0; w < 16; w++) begin
      issue(4'h4, 64'(w * 8), 64'd0, 64'd0, 1'b0);
      issue(4'h4, 64'(12'h780 + w * 8), 64'd0, 64'd0, 1'b0);
    end

    // Write then read back 0xDEAD at 0x10
    issue(4'h4, 64'h10, 64'hDEAD, 64'd0, 1'b0);
    issue(4'h5, 64'h10, 64'd0, 64'd0, 1'b0);

    // pushq 0x55 @0x20 aborted by reset during ADDR
    wait_idle();
    bus.start = 1'b1;
    bus.icode = 4'hA;
    bus.valE  = 64'h20;
    bus.valA  = 64'h55;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_in_addr", {63'd0, bus.busy}, 64'd1);
    check("valM_before_reset", bus.valM, 64'hDEAD);
    rst_n = 1'b0;
    #1;
    check("abort_valM", bus.valM, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_err", {63'd0, bus.dmem_error}, 64'd0);
    ref_valm = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'h5, 64'h20, 64'd0, 64'd0, 1'b0);

    // call/ret at the top word, then popq just past the end
    issue(4'h8, 64'h7F8, 64'd0, 64'h40, 1'b0);
    issue(4'h9, 64'd0, 64'h7F8, 64'd0, 1'b0);
    issue(4'hB, 64'd0, 64'h800, 64'd0, 1'b0);

    // No-access op after a nonzero read keeps valM
    issue(4'h5, 64'h10, 64'd0, 64'd0, 1'b0);
    issue(4'h6, 64'h123, 64'h456, 64'h789, 1'b0);

    // Second start while busy is ignored
    issue(4'h4, 64'h30, 64'hCAFE_F00D, 64'd0, 1'b1);
    issue(4'h5, 64'h30, 64'd0, 64'd0, 1'b0);
    issue(4'h6, 64'd0, 64'd0, 64'd0, 1'b1);

    // Unaligned read
    issue(4'h5, 64'h13, 64'd0, 64'd0, 1'b0);

    // Random traffic
    for (int unsigned t = 0; t < 300; t++) begin
      k = $urandom_range(0, 7);
      if (k < 6) begin
        ic = mem_codes[k];
      end else begin
        do ic = 4'($urandom_range(0, 15));
        while (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
      end
      k = $urandom_range(0, 9);
      if (k < 7)       addr = 64'($urandom_range(0, 15) * 8);
      else if (k < 9)  addr = 64'(12'h780 + $urandom_range(0, 15) * 8);
      else if ($urandom_range(0, 1) == 0) addr = 64'(2048 + $urandom_range(0, 100000));
      else             addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 7) == 0) addr = addr + 64'($urandom_range(1, 7));
      if (ic == 4'h9 || ic == 4'hB)
        issue(ic, {$urandom, $urandom}, addr, {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
      else
        issue(ic, addr, {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
